indexed_array_writer: RTL and testbench



---
 rtl/indexed_array_writer_pkg.sv | 36 +++
 rtl/indexed_array_clear_seq.sv | 52 +++++
 rtl/indexed_array_writer.sv | 63 ++++++
 tb/tb_indexed_array_writer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/indexed_array_writer_pkg.sv
// Shared types, field offsets and defaults for the indexed array writer/reader pair.
package indexed_array_writer_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_N  = 4;
  localparam int DEF_W  = 4;
  localparam int DEF_NB = clog2(DEF_N);
  localparam logic [DEF_N*DEF_W-1:0] DEF_INIT = {4'd4, 4'd3, 4'd2, 4'd1};

  // Input bundle field offsets (nb = index width, w = entry width)
  localparam int I_WR_VALID = 0;
  localparam int I_WR_NDX   = 1;
  function automatic int i_wr_data(input int nb);         return nb + 1;       endfunction
  function automatic int i_clr(input int nb, input int w); return nb + w + 1;  endfunction
  function automatic int i_rd_ndx(input int nb, input int w); return nb + w + 2; endfunction

  // Output bundle field offsets; everything below o_wr_ready is the reader's input
  localparam int O_RD_NDX = 0;
  function automatic int o_arr(input int nb);                         return nb;         endfunction
  function automatic int o_wr_ready(input int n, input int w, input int nb); return nb + n*w; endfunction

  // Reader-facing bundle at default sizing
  typedef struct packed {
    logic [DEF_N-1:0][DEF_W-1:0] arr;
    logic [DEF_NB-1:0]           ndx;
  } rd_bundle_t;

endpackage

// File: rtl/indexed_array_clear_seq.sv
// Clear sequencer: walks clear_ptr over every entry after clr, holds wr_ready low meanwhile.
module indexed_array_clear_seq
  import indexed_array_writer_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int NB = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          clear_en,
  output logic [NB-1:0] clear_ptr,
  output logic          wr_ready
);

  clr_state_e    state_q, state_d;
  logic [NB-1:0] ptr_q, ptr_d;
  logic          ready_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (clr) begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
      CLEAR: begin
        ptr_d = ptr_q + NB'(1);
        if (ptr_q == NB'(N-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == IDLE);
    end
  end

  assign clear_en  = (state_q == CLEAR);
  assign clear_ptr = ptr_q;
  assign wr_ready  = ready_q;

endmodule

// File: rtl/indexed_array_writer.sv
// N-entry register array with valid/ready indexed write, sequenced clear and registered read index.
module indexed_array_writer
  import indexed_array_writer_pkg::*;
#(
  parameter int               N    = DEF_N,
  parameter int               W    = DEF_W,
  parameter int               NB   = clog2(N),
  parameter logic [N*W-1:0]   INIT = DEF_INIT
) (
  input  logic [1:0]          clock_reset,
  input  logic [2*NB+W+1:0]   i,
  output logic [NB+N*W:0]     o
);

  logic clk, rst;
  assign clk = clock_reset[0];
  assign rst = clock_reset[1];

  logic          wr_valid, clr;
  logic [NB-1:0] wr_ndx, rd_ndx;
  logic [W-1:0]  wr_data;

  assign wr_valid = i[I_WR_VALID];
  assign wr_ndx   = i[I_WR_NDX +: NB];
  assign wr_data  = i[i_wr_data(NB) +: W];
  assign clr      = i[i_clr(NB, W)];
  assign rd_ndx   = i[i_rd_ndx(NB, W) +: NB];

  logic          clear_en, wr_ready;
  logic [NB-1:0] clear_ptr;

  indexed_array_clear_seq #(.N(N), .NB(NB)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .clear_en (clear_en),
    .clear_ptr(clear_ptr),
    .wr_ready (wr_ready)
  );

  // Writes only land while ready is high, so they never collide with a clear
  logic                  accept;
  logic [N-1:0][W-1:0]   arr_q;
  logic [NB-1:0]         rd_ndx_q;

  assign accept = wr_valid & wr_ready;

  for (genvar k = 0; k < N; k++) begin : g_ent
    always_ff @(posedge clk) begin
      if (rst)                                      arr_q[k] <= INIT[k*W +: W];
      else if (clear_en && clear_ptr == NB'(k))     arr_q[k] <= '0;
      else if (accept && wr_ndx == NB'(k))          arr_q[k] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_ndx_q <= '0;
    else     rd_ndx_q <= rd_ndx;
  end

  assign o = {wr_ready, arr_q, rd_ndx_q};

endmodule

// File: tb/tb_indexed_array_writer.sv
// Scoreboarded bench for indexed_array_writer at default parameters.
module tb_indexed_array_writer;

  localparam logic [18:0] RST_O = 19'b1_0100_0011_0010_0001_00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  clock_reset;
  logic [9:0]  i = '0;
  logic [18:0] o;

  assign clock_reset = {rst, clk};
  always #5 clk = ~clk;

  indexed_array_writer dut (.clock_reset(clock_reset), .i(i), .o(o));

  int errs = 0, checks = 0;
  logic [18:0] exp_q[$];

  // Reference model state
  logic [3:0] m_arr [4];
  logic       m_ready;
  int         m_left;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] ent(input int k);
    return o[2 + k*4 +: 4];
  endfunction

  function automatic logic [3:0] rdr();
    return o[2 + int'(o[1:0])*4 +: 4];
  endfunction

  // One clock: drive inputs, advance the model, push its prediction, compare after the edge
  task automatic step(input logic wv, input logic [1:0] ndx, input logic [3:0] d,
                      input logic c, input logic [1:0] rd, input logic r);
    logic [18:0] e;
    logic acc;
    rst = r;
    i   = {rd, c, d, ndx, wv};
    if (r) begin
      m_arr[0] = 4'd1; m_arr[1] = 4'd2; m_arr[2] = 4'd3; m_arr[3] = 4'd4;
      m_left = 0; m_ready = 1'b1; rd = 2'd0;
    end else begin
      acc = wv & m_ready;
      if (acc) m_arr[ndx] = d;
      if (m_left > 0) begin
        m_arr[4 - m_left] = 4'd0;
        m_left--;
      end else if (c) begin
        m_left = 4;
      end
      m_ready = (m_left == 0);
    end
    e = {m_ready, m_arr[3], m_arr[2], m_arr[1], m_arr[0], rd};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk("o", 32'(o), 32'(exp_q.pop_front()));
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_o", 32'(o), 32'(RST_O));
    step(0, 0, 0, 0, 3, 0);
    chk("rst_rd3", 32'(rdr()), 32'h4);

    // Single write
    step(1, 2, 4'hA, 0, 2, 0);
    chk("wr_e2", 32'(ent(2)), 32'hA);
    chk("wr_rdq", 32'(o[1:0]), 32'd2);
    chk("wr_rdr", 32'(rdr()), 32'hA);
    chk("wr_oth", {20'd0, ent(3), ent(1), ent(0)}, 32'h421);

    // Clear with writes pressed during it
    step(0, 0, 0, 1, 0, 0);
    chk("clr_rdy0", 32'(o[18]), 32'd0);
    for (int j = 0; j < 4; j++) begin
      step(1, 2'd3, 4'h5, 1, 0, 0);
      chk($sformatf("clr_e%0d", j), 32'(ent(j)), 32'd0);
      chk($sformatf("clr_rdy%0d", j + 1), 32'(o[18]), (j == 3) ? 32'd1 : 32'd0);
    end
    chk("clr_all0", 32'(o[17:2]), 32'd0);

    // Clear together with an accepted write to the same array
    step(1, 1, 4'hF, 1, 1, 0);
    chk("cw_e1F", 32'(ent(1)), 32'hF);
    step(0, 0, 0, 0, 1, 0);
    chk("cw_e1F2", 32'(ent(1)), 32'hF);
    step(0, 0, 0, 0, 1, 0);
    chk("cw_e1z", 32'(ent(1)), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("cw_all0", 32'(o[18:2]), 32'h10000);

    // Reset in the middle of a clear
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("mid_rst", 32'(o), 32'(RST_O));
    step(1, 0, 4'h7, 0, 0, 0);
    chk("mid_wr", 32'(ent(0)), 32'h7);

    // Back-to-back writes
    for (int j = 0; j < 4; j++) begin
      step(1, 2'(j), 4'(8 + j), 0, 2'(j), 0);
      chk($sformatf("b2b_e%0d", j), 32'(ent(j)), 32'(8 + j));
      chk($sformatf("b2b_rdy%0d", j), 32'(o[18]), 32'd1);
    end
    chk("b2b_arr", 32'(o[17:2]), 32'hBA98);

    // Random traffic against the model
    for (int n = 0; n < 200; n++)
      step(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
           ($urandom_range(0, 9) == 0), 2'($urandom), ($urandom_range(0, 39) == 0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
